// File: rtl/pipe_barrel_shifter_if.sv
// Stream interface of the pipelined barrel shifter: an operation channel
// (in_valid/in_ready plus operand fields) and a result channel
// (out_valid/out_ready plus result and zero flag).
interface pipe_barrel_shifter_if #(
    parameter int WIDTH = 8
);
    localparam int SHW = $clog2(WIDTH);

    // Operation channel
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] din;
    logic [SHW-1:0]   shamt;
    logic             LR;
    logic [1:0]       op;

    // Result channel
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dout;
    logic             zero;

    // Producer/consumer side of the shifter
    modport master (
        output in_valid, din, shamt, LR, op, out_ready,
        input  in_ready, out_valid, dout, zero
    );

    // The shifter itself
    modport slave (
        input  in_valid, din, shamt, LR, op, out_ready,
        output in_ready, out_valid, dout, zero
    );
endinterface

// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter / rotator. One registered stage per shift-amount
// bit: stage k shifts or rotates by 2^k when shamt[k] is set. The last stage
// register is the output register. All stages advance together whenever the
// output is empty or being consumed, so backpressure stalls the whole pipe
// without dropping operations and bubbles travel as invalid entries.
module pipe_barrel_shifter #(
    parameter int WIDTH = 8
) (
    input logic                 clk,
    input logic                 rst,
    pipe_barrel_shifter_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        OP_LOGIC    = 2'b00,
        OP_ARITH    = 2'b01,
        OP_ROTATE   = 2'b10,
        OP_RESERVED = 2'b11   // behaves as a logical shift
    } op_e;

    // Everything an operation carries down the pipe. The sign is captured
    // once from the operand so arithmetic fill never depends on intermediate
    // values.
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
        logic [SHW-1:0]   shamt;
        logic             lr;
        op_e              op;
        logic             sign;
    } stage_t;

    // Shift or rotate by a fixed power-of-two amount (always < WIDTH).
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] d,
        input int unsigned      amt,
        input logic             lr,
        input op_e              op,
        input logic             sign
    );
        logic [WIDTH-1:0] fill_mask;
        logic [WIDTH-1:0] res;
        fill_mask = ~({WIDTH{1'b1}} >> amt);
        case (op)
            OP_ROTATE: begin
                if (lr) res = (d << amt) | (d >> (WIDTH - amt));
                else    res = (d >> amt) | (d << (WIDTH - amt));
            end
            OP_ARITH: begin
                // Arithmetic left is the same as logical left.
                if (lr)        res = d << amt;
                else if (sign) res = (d >> amt) | fill_mask;
                else           res = d >> amt;
            end
            default: begin
                if (lr) res = d << amt;
                else    res = d >> amt;
            end
        endcase
        return res;
    endfunction

    stage_t stg_q   [SHW];   // stage registers; stg_q[SHW-1] is the output
    stage_t stg_src [SHW];   // value presented to each stage
    stage_t stg_d   [SHW];   // value each stage loads on advance
    logic   zero_q;
    logic   adv;

    // Single global advance: the pipe moves only if the output can drain.
    assign adv          = !stg_q[SHW-1].valid || bus.out_ready;
    assign bus.in_ready = adv;
    assign bus.out_valid = stg_q[SHW-1].valid;
    assign bus.dout      = stg_q[SHW-1].data;
    assign bus.zero      = zero_q;

    // Route each stage's source and apply its conditional 2^k shift.
    always_comb begin
        // NOTE: every element is assigned before any branch reads or modifies it,
        // so no path leaves a value held from a previous evaluation (no latch).
        stg_src[0].valid = bus.in_valid && adv;
        stg_src[0].data  = bus.din;
        stg_src[0].shamt = bus.shamt;
        stg_src[0].lr    = bus.LR;
        stg_src[0].op    = op_e'(bus.op);
        stg_src[0].sign  = bus.din[WIDTH-1];
        for (int k = 1; k < SHW; k++) begin
            stg_src[k] = stg_q[k-1];
        end
        for (int k = 0; k < SHW; k++) begin
            stg_d[k] = stg_src[k];
            if (stg_src[k].shamt[k]) begin
                stg_d[k].data = shift_step(stg_src[k].data, 1 << k,
                                           stg_src[k].lr, stg_src[k].op,
                                           stg_src[k].sign);
            end
        end
    end

    // Stage registers and zero flag: reset clears, advance loads, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data fields are reset too, not just the valid bits,
            // because dout and zero must read 0 straight after reset.
            for (int k = 0; k < SHW; k++) begin
                stg_q[k] <= '0;
            end
            zero_q <= 1'b0;
        end else if (adv) begin
            // NOTE: non-blocking assignments let every stage sample its
            // predecessor's old value, which is what makes this a pipeline.
            for (int k = 0; k < SHW; k++) begin
                stg_q[k] <= stg_d[k];
            end
            zero_q <= stg_d[SHW-1].valid && (stg_d[SHW-1].data == '0);
        end
    end

    // A stalled result must not change until the consumer takes it.
    a_hold_stable: assert property (
        @(posedge clk) disable iff (rst)
        (bus.out_valid && !bus.out_ready) |=>
            (bus.out_valid && $stable(bus.dout) && $stable(bus.zero))
    );

    // While stalled nothing new may be accepted.
    a_no_accept_on_stall: assert property (
        @(posedge clk) disable iff (rst)
        (bus.out_valid && !bus.out_ready) |-> !bus.in_ready
    );
endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Self-checking bench for pipe_barrel_shifter at WIDTH=8 and WIDTH=32.
// A bit-level reference model fills a scoreboard per instance on every
// accepted operation; a monitor compares every valid output cycle against it.
module tb_pipe_barrel_shifter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_barrel_shifter_if #(.WIDTH(8))  bus8 ();
    pipe_barrel_shifter_if #(.WIDTH(32)) bus32 ();

    pipe_barrel_shifter #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
    pipe_barrel_shifter #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));

    int checks = 0;
    int errors = 0;
    logic [31:0] q8  [$];
    logic [31:0] q32 [$];
    int pops8 = 0;

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] s;
        logic       lr;
        logic [1:0] op;
        logic [7:0] exp;
    } vec8_t;

    localparam vec8_t DIR8 [12] = '{
        '{8'h96, 3'd3, 1'b0, 2'b01, 8'hF2},
        '{8'h96, 3'd3, 1'b0, 2'b00, 8'h12},
        '{8'h96, 3'd3, 1'b0, 2'b10, 8'hD2},
        '{8'h96, 3'd3, 1'b1, 2'b00, 8'hB0},
        '{8'h96, 3'd1, 1'b1, 2'b10, 8'h2D},
        '{8'h96, 3'd3, 1'b1, 2'b01, 8'hB0},
        '{8'h01, 3'd1, 1'b0, 2'b00, 8'h00},
        '{8'hA5, 3'd0, 1'b0, 2'b00, 8'hA5},
        '{8'hA5, 3'd0, 1'b0, 2'b01, 8'hA5},
        '{8'hA5, 3'd0, 1'b1, 2'b10, 8'hA5},
        '{8'hA5, 3'd0, 1'b0, 2'b11, 8'hA5},
        '{8'h80, 3'd7, 1'b0, 2'b00, 8'h01}
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: each result bit is picked from its source bit by the rules
    // of the mode, for a w-bit operand.
    function automatic logic [31:0] model(input logic [31:0] d, input int s,
                                          input logic lr, input logic [1:0] op,
                                          input int w);
        logic [31:0] r;
        logic sign;
        r = '0;
        sign = d[w-1];
        for (int i = 0; i < w; i++) begin
            if (op == 2'b10) begin
                if (lr) r[i] = d[(i - s + w) % w];
                else    r[i] = d[(i + s) % w];
            end else if (lr) begin
                if (i - s >= 0) r[i] = d[i - s];
                else            r[i] = 1'b0;
            end else begin
                if (i + s < w)  r[i] = d[i + s];
                else            r[i] = (op == 2'b01) ? sign : 1'b0;
            end
        end
        return r;
    endfunction

    // Scoreboard / compare for the 8-bit instance.
    always @(negedge clk) begin
        if (rst) begin
            q8.delete();
        end else begin
            if (bus8.out_valid) begin
                if (q8.size() == 0) begin
                    check("spurious_valid8", 32'(bus8.out_valid), 32'd0);
                end else begin
                    check("dout8", 32'(bus8.dout), q8[0]);
                    check("zero8", 32'(bus8.zero), 32'(q8[0] == 32'd0));
                    if (bus8.out_ready) begin
                        void'(q8.pop_front());
                        pops8++;
                    end
                end
            end
            if (bus8.in_valid && bus8.in_ready)
                q8.push_back(model(32'(bus8.din), int'(bus8.shamt), bus8.LR, bus8.op, 8));
        end
    end

    // Scoreboard / compare for the 32-bit instance.
    always @(negedge clk) begin
        if (rst) begin
            q32.delete();
        end else begin
            if (bus32.out_valid) begin
                if (q32.size() == 0) begin
                    check("spurious_valid32", 32'(bus32.out_valid), 32'd0);
                end else begin
                    check("dout32", bus32.dout, q32[0]);
                    check("zero32", 32'(bus32.zero), 32'(q32[0] == 32'd0));
                    if (bus32.out_ready) void'(q32.pop_front());
                end
            end
            if (bus32.in_valid && bus32.in_ready)
                q32.push_back(model(bus32.din, int'(bus32.shamt), bus32.LR, bus32.op, 32));
        end
    end

    // Present one operation and hold it until accepted; returns #1 after the accepting edge.
    task automatic issue8(input logic [7:0] d, input int s, input logic lr, input logic [1:0] o);
        bit acc;
        int guard;
        guard = 0;
        bus8.in_valid = 1'b1;
        bus8.din      = d;
        bus8.shamt    = 3'(s);
        bus8.LR       = lr;
        bus8.op       = o;
        do begin
            @(negedge clk);
            acc = bus8.in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 50);
        check("accept8", 32'(acc), 32'd1);
        bus8.in_valid = 1'b0;
    endtask

    task automatic issue32(input logic [31:0] d, input int s, input logic lr, input logic [1:0] o);
        bit acc;
        int guard;
        guard = 0;
        bus32.in_valid = 1'b1;
        bus32.din      = d;
        bus32.shamt    = 5'(s);
        bus32.LR       = lr;
        bus32.op       = o;
        do begin
            @(negedge clk);
            acc = bus32.in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 50);
        check("accept32", 32'(acc), 32'd1);
        bus32.in_valid = 1'b0;
    endtask

    // One operation into an idle pipe: checks latency, result and zero flag.
    task automatic run_one8(input string name, input logic [7:0] d, input int s,
                            input logic lr, input logic [1:0] o, input logic [7:0] exp);
        int lat;
        bus8.out_ready = 1'b1;
        issue8(d, s, lr, o);
        lat = 1;
        while (!bus8.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_lat"}, 32'(lat), 32'd3);
        check(name, 32'(bus8.dout), 32'(exp));
        check({name, "_zero"}, 32'(bus8.zero), 32'(exp == 8'h00));
    endtask

    task automatic run_one32(input string name, input logic [31:0] d, input int s,
                             input logic lr, input logic [1:0] o, input logic [31:0] exp);
        int lat;
        bus32.out_ready = 1'b1;
        issue32(d, s, lr, o);
        lat = 1;
        while (!bus32.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_lat"}, 32'(lat), 32'd5);
        check(name, bus32.dout, exp);
        check({name, "_zero"}, 32'(bus32.zero), 32'(exp == 32'd0));
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        bus8.in_valid  = 1'b0; bus8.din  = '0; bus8.shamt  = '0; bus8.LR  = 1'b0; bus8.op  = 2'b00;
        bus8.out_ready = 1'b1;
        bus32.in_valid = 1'b0; bus32.din = '0; bus32.shamt = '0; bus32.LR = 1'b0; bus32.op = 2'b00;
        bus32.out_ready = 1'b1;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid8", 32'(bus8.out_valid), 32'd0);
        check("rst_dout8",      32'(bus8.dout),      32'd0);
        check("rst_zero8",      32'(bus8.zero),      32'd0);
        check("rst_in_ready8",  32'(bus8.in_ready),  32'd1);
        check("rst_out_valid32", 32'(bus32.out_valid), 32'd0);
        check("rst_dout32",      bus32.dout,           32'd0);
        check("rst_in_ready32",  32'(bus32.in_ready),  32'd1);

        // Directed vectors with hand-computed results
        for (int i = 0; i < 12; i++) begin
            run_one8($sformatf("dir8_%0d", i), DIR8[i].d, int'(DIR8[i].s),
                     DIR8[i].lr, DIR8[i].op, DIR8[i].exp);
        end
        run_one32("dir32_asr31", 32'h8000_0000, 31, 1'b0, 2'b01, 32'hFFFF_FFFF);
        run_one32("dir32_lsr31", 32'h8000_0000, 31, 1'b0, 2'b00, 32'h0000_0001);
        run_one32("dir32_rol1",  32'h8000_0000, 1,  1'b1, 2'b10, 32'h0000_0001);
        repeat (6) @(posedge clk);
        #1;

        // Backpressure: four back-to-back ops, consumer stalls 5 cycles at first result
        pops8 = 0;
        bus8.out_ready = 1'b0;
        fork
            begin
                issue8(8'h96, 3, 1'b0, 2'b01);
                issue8(8'h96, 3, 1'b1, 2'b00);
                issue8(8'h96, 1, 1'b1, 2'b10);
                issue8(8'h80, 7, 1'b0, 2'b00);
            end
            begin
                int w;
                w = 0;
                while (!bus8.out_valid && w < 30) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                check("bp_first_valid", 32'(bus8.out_valid), 32'd1);
                repeat (5) begin
                    check("bp_in_ready", 32'(bus8.in_ready), 32'd0);
                    check("bp_hold_dout", 32'(bus8.dout), 32'hF2);
                    @(posedge clk);
                    #1;
                end
                bus8.out_ready = 1'b1;
            end
        join
        g = 0;
        while (pops8 < 4 && g < 30) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("bp_delivered", 32'(pops8), 32'd4);
        repeat (4) @(posedge clk);
        #1;
        check("bp_no_extra", 32'(pops8), 32'd4);

        // Reset with three operations in flight
        issue8(8'h11, 1, 1'b1, 2'b00);
        issue8(8'h22, 2, 1'b0, 2'b10);
        issue8(8'h33, 3, 1'b0, 2'b01);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_out_valid", 32'(bus8.out_valid), 32'd0);
        check("midrst_dout",      32'(bus8.dout),      32'd0);
        check("midrst_zero",      32'(bus8.zero),      32'd0);
        repeat (5) begin
            @(posedge clk);
            #1;
            check("midrst_no_stale", 32'(bus8.out_valid), 32'd0);
        end
        run_one8("post_rst", 8'h96, 3, 1'b0, 2'b10, 8'hD2);
        run_one32("post_rst32", 32'h8000_0000, 31, 1'b0, 2'b01, 32'hFFFF_FFFF);

        // Randomised traffic with random bubbles and backpressure on both widths
        fork
            begin
                repeat (500) begin
                    bus8.in_valid  = ($urandom_range(0, 3) != 0);
                    bus8.din       = 8'($urandom);
                    bus8.shamt     = 3'($urandom);
                    bus8.LR        = 1'($urandom);
                    bus8.op        = 2'($urandom);
                    bus8.out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                bus8.in_valid  = 1'b0;
                bus8.out_ready = 1'b1;
            end
            begin
                repeat (500) begin
                    bus32.in_valid  = ($urandom_range(0, 2) != 0);
                    bus32.din       = $urandom;
                    bus32.shamt     = 5'($urandom);
                    bus32.LR        = 1'($urandom);
                    bus32.op        = 2'($urandom);
                    bus32.out_ready = ($urandom_range(0, 2) != 0);
                    @(posedge clk);
                    #1;
                end
                bus32.in_valid  = 1'b0;
                bus32.out_ready = 1'b1;
            end
        join
        g = 0;
        while ((q8.size() != 0 || q32.size() != 0) && g < 40) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("drain8",  32'(q8.size()),  32'd0);
        check("drain32", 32'(q32.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
